issue_scoreboard: RTL
=====================

# issue_scoreboard

Issue controller between instruction decode and execute. Tracks outstanding register writes per architectural register and holds a decoded instruction while it reads a register still pending writeback (RAW) or would overflow a register's pending count. Passes `valid`/`ready` straight through otherwise, with zero added latency. On `flush` it quiesces issue and discards all pending-write state.

## Interface
Parameters:
- `NREG`, 32: number of architectural registers; register 0 is hardwired zero and never tracked.
- `MAX_INFLIGHT`, 3: maximum outstanding writes per register. Counter width is `CW = $clog2(MAX_INFLIGHT+1)`.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1: a decoded instruction is offered.
- `in_ready` out 1: the scoreboard accepts the offered instruction.
- `in_rs1` in 5: source register 1 index; 0 means no source.
- `in_rs2` in 5: source register 2 index; 0 means no source.
- `in_rd` in 5: destination register index; 0 means no write.
- `out_valid` out 1: an instruction is offered to execute.
- `out_ready` in 1: execute accepts the instruction.
- `wb_valid` in 1: one register write retires this cycle.
- `wb_rd` in 5: index of the retiring register.
- `flush` in 1: pipeline flush request.
- `busy` out 1: at least one pending counter is nonzero.
- `stall_cnt` out 16: hazard-stall cycle count. Present only with the configuration macro.

## Operation
- **State.** Keep `cnt[1..NREG-1]` (each `CW` bits) and `state` ∈ {RUN, HOLD}.
- **Hazard.** `hazard` is asserted when any of the following holds:
  - `in_rs1 != 0` and `cnt[in_rs1] != 0`;
  - `in_rs2 != 0` and `cnt[in_rs2] != 0`;
  - `in_rd != 0` and `cnt[in_rd] == MAX_INFLIGHT`.
- **Handshake in RUN:**
  - `out_valid = in_valid & ~hazard`
  - `in_ready = out_ready & ~hazard`
  - Fire is `in_valid & in_ready`.
  - A hazard never drops `out_valid` once it has been asserted: the hazard inputs depend only on `in_*`, and those must be held stable while `in_valid & ~in_ready`.
- **Counter updates, evaluated together each edge:**
  - Increment: fire with `in_rd != 0` increments `cnt[in_rd]`.
  - Decrement: `wb_valid` with `wb_rd != 0` and `cnt[wb_rd] != 0` decrements `cnt[wb_rd]`. A writeback to a zero counter is ignored; this is legal after a flush.
  - Increment and decrement on the same register in the same cycle leave the count unchanged.
- **Flush.**
  - While `flush` is high, `in_ready = 0` and `out_valid = 0`.
  - At the edge, every `cnt` is cleared, any same-cycle increment or decrement is discarded, and `state` moves to HOLD.
- **HOLD.**
  - `in_ready = 0` and `out_valid = 0` for exactly one cycle, then `state` returns to RUN.
  - A `flush` during HOLD re-clears the counters and stays in HOLD one more cycle.
  - Writebacks during HOLD are applied, normally hitting zero counters and so ignored.
- **`busy`** is the OR of all `cnt != 0`.

## Timing
- Issue path is combinational: `in_*` → `out_valid`/`in_ready` in the same cycle.
- Writeback is visible to the hazard check the cycle after `wb_valid`. There is no same-cycle bypass.
- A fire is visible to the next instruction's hazard check the following cycle. Back-to-back dependent instructions therefore stall until writeback.
- Reset:
  - While `rst` is low: all `cnt = 0`, `state = RUN`, `stall_cnt = 0`.
  - `in_ready`, `out_valid` and `busy` are forced to 0 while `rst` is low.
  - Asynchronous assertion in mid-operation discards all pending state immediately.
- `flush` has priority over fire and writeback in the same cycle.

## Configuration
- Macro: `ISSUE_SCOREBOARD_STALL_CNT_EN`.
- **Defined:**
  - `stall_cnt` port exists.
  - It increments by 1 on each cycle with `state == RUN & in_valid & hazard & ~flush`.
  - It saturates at 16'hFFFF and is cleared only by reset.
- **Undefined:** the `stall_cnt` port and its register are absent. All other behaviour is identical.

## Test plan
- **Independent stream.**
  - Stimulus: fire `rd=5` with `out_ready=1`, then next cycle offer `rs1=6, rs2=7`.
  - Required: second instruction issues immediately; `cnt[5]=1`; `busy=1`.
- **RAW stall.**
  - Stimulus: fire `rd=5`, then offer `rs1=5`.
  - Required: `out_valid=0` and `in_ready=0` until the cycle after `wb_valid` with `wb_rd=5`, then the instruction issues. With the macro, `stall_cnt` equals the number of stalled cycles.
- **Saturation.**
  - Stimulus: three fires with `rd=9`, no writeback, then a fourth `rd=9`.
  - Required: the fourth stalls. One writeback to `rd=9` lets it issue the next cycle, and `cnt[9]` remains 3.
- **Simultaneous increment and decrement.**
  - Stimulus: with `cnt[3]=1`, fire `rd=3` in the same cycle as `wb_rd=3`.
  - Required: `cnt[3]` stays 1.
- **Flush.**
  - Stimulus: with `cnt[4]=2` and `cnt[8]=1`, assert `flush` for one cycle alongside an offered instruction.
  - Required: no issue in the flush cycle or the following HOLD cycle. All counters read 0 and `busy=0`. A later `wb_rd=4` is ignored. `rs1=4` issues in the first RUN cycle.
- **Reset mid-stall.**
  - Stimulus: assert `rst=0` asynchronously while stalled on `rs1=5`.
  - Required: immediately `in_ready=0`, `out_valid=0`, `busy=0`. After release, `rs1=5` issues without stalling.

Source files
------------

// File: rtl/issue_scoreboard.sv
// Issue scoreboard: per-register pending-write counters gate decode->execute issue on RAW/overflow hazards.
// Optional hazard-stall counter port enabled by ISSUE_SCOREBOARD_STALL_CNT_EN.
module issue_scoreboard #(
  parameter int NREG         = 32,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] in_rs1,
  input  logic [4:0] in_rs2,
  input  logic [4:0] in_rd,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic       wb_valid,
  input  logic [4:0] wb_rd,
  input  logic       flush,
  output logic       busy
`ifdef ISSUE_SCOREBOARD_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic {RUN, HOLD} state_t;

  state_t          state;
  logic [CW-1:0]   cnt [NREG];
  logic            hazard;
  logic            open;
  logic            fire;
  logic            any_pend;
  logic [NREG-1:1] inc_v;
  logic [NREG-1:1] dec_v;

  always_comb begin
    hazard = ((in_rs1 != '0) && (cnt[in_rs1] != '0)) ||
             ((in_rs2 != '0) && (cnt[in_rs2] != '0)) ||
             ((in_rd  != '0) && (cnt[in_rd]  == CW'(MAX_INFLIGHT)));
  end

  // Issue path stays combinational; reset, flush and HOLD all close it.
  assign open      = rst && (state == RUN) && !flush;
  assign in_ready  = open && out_ready && !hazard;
  assign out_valid = open && in_valid && !hazard;
  assign fire      = in_valid && in_ready;

  always_comb begin
    any_pend = 1'b0;
    inc_v    = '0;
    dec_v    = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      any_pend = any_pend | (cnt[i] != '0);
      inc_v[i] = fire && (in_rd == 5'(i));
      dec_v[i] = wb_valid && (wb_rd == 5'(i)) && (cnt[i] != '0);
    end
  end

  assign busy = rst && any_pend;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      for (int unsigned i = 0; i < NREG; i++) cnt[i] <= '0;
    end else begin
      state <= flush ? HOLD : RUN;
      for (int unsigned i = 1; i < NREG; i++) begin
        if (flush)
          cnt[i] <= '0;
        else if (inc_v[i] && !dec_v[i])
          cnt[i] <= cnt[i] + CW'(1);
        else if (dec_v[i] && !inc_v[i])
          cnt[i] <= cnt[i] - CW'(1);
      end
    end
  end

`ifdef ISSUE_SCOREBOARD_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= '0;
    else if ((state == RUN) && in_valid && hazard && !flush && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule
